// File: rtl/cpu_sequencer.sv
// CPU sequencer: gates control_unit state advance by run/step/halt mode and retires instructions.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  next_state,
    input  logic        halt,
    input  logic        run,
    input  logic        step,
    output logic [2:0]  state,
    output logic        cpu_en,
    output logic [1:0]  mode,
    output logic        retire,
    output logic        bad_state,
    output logic [15:0] cycle_count,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101
    } cpu_state_e;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_HALTED = 2'b11
    } seq_mode_e;

    cpu_state_e state_q, state_d;
    seq_mode_e  mode_q, mode_d;
    logic       bad_state_q, bad_state_d;
    logic       halt_evt, illegal_evt, boundary;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            mode_q      <= MODE_IDLE;
            bad_state_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bad_state_q <= bad_state_d;
        end
    end

    // Halt outranks both the illegal-state recovery and the boundary rule.
    always_comb begin
        cpu_en      = !reset && (mode_q == MODE_RUN || mode_q == MODE_STEP);
        halt_evt    = cpu_en && (halt || next_state == HALT_STATE);
        illegal_evt = cpu_en && !halt_evt && (next_state[2:1] == 2'b11);
        boundary    = cpu_en && !halt_evt && (state_q != FETCH) && (next_state == FETCH);
        retire      = boundary;

        state_d     = state_q;
        mode_d      = mode_q;
        bad_state_d = bad_state_q;

        if (halt_evt) begin
            state_d = HALT_STATE;
            mode_d  = MODE_HALTED;
        end else if (illegal_evt) begin
            state_d     = FETCH;
            mode_d      = MODE_IDLE;
            bad_state_d = 1'b1;
        end else begin
            if (cpu_en) begin
                state_d = cpu_state_e'(next_state);
            end
            case (mode_q)
                MODE_IDLE: begin
                    if (run) begin
                        mode_d = MODE_RUN;
                    end else if (step) begin
                        mode_d = MODE_STEP;
                    end
                end
                MODE_RUN: begin
                    if (boundary && !run) begin
                        mode_d = MODE_IDLE;
                    end
                end
                MODE_STEP: begin
                    if (boundary) begin
                        mode_d = MODE_IDLE;
                    end
                end
                default: mode_d = MODE_HALTED;
            endcase
        end
    end

    assign state     = state_q;
    assign mode      = mode_q;
    assign bad_state = bad_state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [15:0] instr_count_q, instr_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (cpu_en && cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end
        if (retire && instr_count_q != '1) begin
            instr_count_d = instr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; counter expectations follow SEQ_PERF_CNT_EN.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic [2:0]  next_state;
    logic        halt;
    logic        run;
    logic        step;
    logic [2:0]  state;
    logic        cpu_en;
    logic [1:0]  mode;
    logic        retire;
    logic        bad_state;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .next_state  (next_state),
        .halt        (halt),
        .run         (run),
        .step        (step),
        .state       (state),
        .cpu_en      (cpu_en),
        .mode        (mode),
        .retire      (retire),
        .bad_state   (bad_state),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0; next_state = 3'b000;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        run = 1'b1; next_state = 3'b001;
        tick();
        tick();
        next_state = 3'b010;
        tick();
        checks++;
        if (state !== 3'b010) begin errors++; $display("FAIL pre_reset_state got %0h exp 2", state); end
        reset = 1'b1; next_state = 3'b000;
        #1;
        checks++;
        if (cpu_en !== 1'b0 || retire !== 1'b0) begin
            errors++; $display("FAIL reset_en_retire got %0b%0b exp 00", cpu_en, retire);
        end
        tick();
        reset = 1'b0; run = 1'b0;
        #1;
        checks++;
        if (state !== 3'b000 || mode !== 2'b00 || cpu_en !== 1'b0 || bad_state !== 1'b0) begin
            errors++; $display("FAIL reset_state got st=%0h md=%0h en=%0b bad=%0b exp 0 0 0 0", state, mode, cpu_en, bad_state);
        end
        checks++;
        if (cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            errors++; $display("FAIL reset_counts got %0h %0h exp 0 0", cycle_count, instr_count);
        end
    endtask

    task automatic test_step();
        logic [2:0] seq [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
        do_reset();
        step = 1'b1; next_state = 3'b001;
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin errors++; $display("FAIL idle_cpu_en got %0b exp 0", cpu_en); end
        tick();
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_state = seq[i];
            #1;
            checks++;
            if (mode !== 2'b10 || cpu_en !== 1'b1 || retire !== (i == 4)) begin
                errors++; $display("FAIL step_cycle%0d got md=%0h en=%0b ret=%0b exp 2 1 %0b", i, mode, cpu_en, retire, (i == 4));
            end
            tick();
        end
        checks++;
        if (mode !== 2'b00 || state !== 3'b000) begin
            errors++; $display("FAIL step_done got md=%0h st=%0h exp 0 0", mode, state);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (instr_count !== 16'd1 || cycle_count !== 16'd5) begin
            errors++; $display("FAIL step_counts got i=%0d c=%0d exp 1 5", instr_count, cycle_count);
        end
`else
        checks++;
        if (instr_count !== 16'd0 || cycle_count !== 16'd0) begin
            errors++; $display("FAIL step_counts got i=%0d c=%0d exp 0 0", instr_count, cycle_count);
        end
`endif
        next_state = 3'b001;
        tick();
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL step_no_advance got %0h exp 0", state); end
    endtask

    task automatic test_run_drop();
        do_reset();
        run = 1'b1; next_state = 3'b001;
        tick();
        tick();
        next_state = 3'b010;
        tick();
        run = 1'b0; next_state = 3'b011;
        #1;
        checks++;
        if (retire !== 1'b0) begin errors++; $display("FAIL drop_no_retire got %0b exp 0", retire); end
        tick();
        checks++;
        if (state !== 3'b011 || mode !== 2'b01) begin
            errors++; $display("FAIL drop_continue got st=%0h md=%0h exp 3 1", state, mode);
        end
        next_state = 3'b100;
        tick();
        next_state = 3'b000;
        #1;
        checks++;
        if (retire !== 1'b1) begin errors++; $display("FAIL drop_retire got %0b exp 1", retire); end
        tick();
        checks++;
        if (state !== 3'b000 || mode !== 2'b00) begin
            errors++; $display("FAIL drop_idle got st=%0h md=%0h exp 0 0", state, mode);
        end
        next_state = 3'b001;
        tick();
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL drop_hold got %0h exp 0", state); end
    endtask

    task automatic test_back_to_back();
        int unsigned rets = 0;
        logic [2:0] seq [4] = '{3'b001, 3'b000, 3'b001, 3'b000};
        do_reset();
        run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            next_state = seq[i];
            #1;
            if (retire === 1'b1) rets++;
            tick();
        end
        checks++;
        if (rets != 2 || mode !== 2'b01) begin
            errors++; $display("FAIL b2b got rets=%0d md=%0h exp 2 1", rets, mode);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (instr_count !== 16'd2 || cycle_count !== 16'd4) begin
            errors++; $display("FAIL b2b_counts got i=%0d c=%0d exp 2 4", instr_count, cycle_count);
        end
`endif
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1; next_state = 3'b001;
        tick();
        tick();
        next_state = 3'b010;
        tick();
        halt = 1'b1; next_state = 3'b011;
        tick();
        halt = 1'b0;
        #1;
        checks++;
        if (mode !== 2'b11 || state !== 3'b101 || cpu_en !== 1'b0) begin
            errors++; $display("FAIL halt_enter got md=%0h st=%0h en=%0b exp 3 5 0", mode, state, cpu_en);
        end
        run = 1'b1; step = 1'b1; next_state = 3'b001;
        tick();
        tick();
        checks++;
        if (mode !== 2'b11 || state !== 3'b101) begin
            errors++; $display("FAIL halt_sticky got md=%0h st=%0h exp 3 5", mode, state);
        end
        do_reset();
        checks++;
        if (mode !== 2'b00 || state !== 3'b000) begin
            errors++; $display("FAIL halt_exit got md=%0h st=%0h exp 0 0", mode, state);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        run = 1'b1; next_state = 3'b001;
        tick();
        tick();
        next_state = 3'b111;
        #1;
        checks++;
        if (retire !== 1'b0) begin errors++; $display("FAIL illegal_retire got %0b exp 0", retire); end
        tick();
        run = 1'b0;
        checks++;
        if (state !== 3'b000 || bad_state !== 1'b1 || mode !== 2'b00) begin
            errors++; $display("FAIL illegal got st=%0h bad=%0b md=%0h exp 0 1 0", state, bad_state, mode);
        end
        step = 1'b1; next_state = 3'b001;
        tick();
        step = 1'b0;
        tick();
        next_state = 3'b000;
        tick();
        checks++;
        if (bad_state !== 1'b1 || mode !== 2'b00) begin
            errors++; $display("FAIL illegal_sticky got bad=%0b md=%0h exp 1 0", bad_state, mode);
        end
    endtask

    task automatic test_priority();
        do_reset();
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (mode !== 2'b01) begin errors++; $display("FAIL run_over_step got %0h exp 1", mode); end
        halt = 1'b1; next_state = 3'b110;
        tick();
        halt = 1'b0;
        checks++;
        if (mode !== 2'b11 || state !== 3'b101 || bad_state !== 1'b0) begin
            errors++; $display("FAIL halt_over_illegal got md=%0h st=%0h bad=%0b exp 3 5 0", mode, state, bad_state);
        end
        do_reset();
        run = 1'b1; next_state = 3'b001;
        tick();
        tick();
        halt = 1'b1; next_state = 3'b000;
        #1;
        checks++;
        if (retire !== 1'b0) begin errors++; $display("FAIL halt_over_boundary got %0b exp 0", retire); end
        tick();
        halt = 1'b0;
        checks++;
        if (mode !== 2'b11 || state !== 3'b101) begin
            errors++; $display("FAIL halt_boundary_mode got md=%0h st=%0h exp 3 5", mode, state);
        end
        do_reset();
        run = 1'b1; next_state = 3'b101;
        tick();
        tick();
        checks++;
        if (mode !== 2'b11 || state !== 3'b101) begin
            errors++; $display("FAIL halt_by_state got md=%0h st=%0h exp 3 5", mode, state);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        run = 1'b1; next_state = 3'b000;
        tick();
        repeat (65534) tick();
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (cycle_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %0h exp fffe", cycle_count); end
        repeat (3) tick();
        checks++;
        if (cycle_count !== 16'hFFFF || instr_count !== 16'd0) begin
            errors++; $display("FAIL sat_hold got c=%0h i=%0h exp ffff 0", cycle_count, instr_count);
        end
`else
        checks++;
        if (cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            errors++; $display("FAIL counts_disabled got c=%0h i=%0h exp 0 0", cycle_count, instr_count);
        end
`endif
        run = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0; next_state = 3'b000;
        test_reset();
        test_step();
        test_run_drop();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_priority();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 next_state  input  3  next FSM state from control_unit (FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, HALT_STATE=101).
REQ-005 halt  input  1  halt request from control_unit.
REQ-006 run  input  1  level: free-run the CPU while high.
REQ-007 step  input  1  single-cycle pulse: execute exactly one instruction.
REQ-008 state  output  3  registered CPU FSM state driven to control_unit.
REQ-009 cpu_en  output  1  combinational: datapath write enables are allowed this cycle.
REQ-010 mode  output  2  sequencer mode (IDLE=00, RUN=01, STEP=10, HALTED=11).
REQ-011 retire  output  1  one-cycle pulse per completed instruction.
REQ-012 bad_state  output  1  sticky: illegal next_state (110/111) was seen.
REQ-013 cycle_count  output  16  cycles with cpu_en=1.
REQ-014 instr_count  output  16  retired instructions.

Function
REQ-015 cpu_en SHALL be 1 exactly when mode is RUN or STEP; it SHALL be 0 in IDLE and HALTED.
REQ-016 When cpu_en=1, state SHALL load next_state on the clock edge; when cpu_en=0, state SHALL hold.
REQ-017 IDLE: run=1 SHALL move mode to RUN at the next edge; otherwise step=1 SHALL move it to STEP; run takes priority if both are high.
REQ-018 The first state advance SHALL occur on the edge after mode enters RUN or STEP, which gives a 1-cycle start latency.
REQ-019 A boundary SHALL be defined as cpu_en=1, state!=FETCH and next_state=FETCH; at a boundary retire SHALL pulse in that same cycle (combinational).
REQ-020 STEP SHALL return to IDLE at the edge of its first boundary.
REQ-021 RUN with run=0 SHALL continue until the next boundary and then return to IDLE, so it never stops mid-instruction.
REQ-022 step pulses in RUN or STEP SHALL be ignored.
REQ-023 With cpu_en=1, halt=1 or next_state=HALT_STATE SHALL set mode to HALTED and state to HALT_STATE at the next edge, with no retire pulse.
REQ-024 HALTED SHALL be exited only by reset; run and step SHALL be ignored.
REQ-025 With cpu_en=1, next_state of 110 or 111 SHALL load FETCH instead, set bad_state, and change mode to IDLE.
REQ-026 Halt SHALL take priority over an illegal next_state and over the boundary rule.

Reset
REQ-027 reset=1 SHALL at the next edge set state=FETCH, mode=IDLE, bad_state=0, cycle_count=0 and instr_count=0, overriding all other inputs.
REQ-028 While reset=1, cpu_en and retire SHALL be 0.
REQ-029 Reset mid-instruction SHALL abandon that instruction with no retire.

Configuration
REQ-030 Macro SEQ_PERF_CNT_EN SHALL control the counters.
REQ-031 When SEQ_PERF_CNT_EN is defined, cycle_count SHALL increment on each cpu_en=1 cycle, instr_count SHALL increment on each retire, and both SHALL saturate at 16'hFFFF.
REQ-032 When SEQ_PERF_CNT_EN is undefined, cycle_count and instr_count SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-033 Reset with run=1, state=EXECUTE -> next cycle state=000, mode=00, cpu_en=0, counts=0.
REQ-034 IDLE, step=1 for one cycle, next_state cycles 001,010,011,100,000 -> mode=10 for 5 cycles, retire once, then mode=00 and state=000; instr_count=1 and cycle_count=5 when SEQ_PERF_CNT_EN is defined.
REQ-035 RUN, run dropped while state=010 -> state advances through 011,100 to 000, retire pulses, mode=00, no further advance.
REQ-036 RUN, halt=1 at state=010 -> next cycle mode=11, state=101; later run=1 and step=1 -> no change until reset.
REQ-037 RUN, next_state=111 -> state=000, bad_state=1, mode=00; bad_state stays 1 after a new step.
REQ-038 SEQ_PERF_CNT_EN defined, cycle_count preloaded to 16'hFFFE via long run -> holds 16'hFFFF thereafter; with SEQ_PERF_CNT_EN undefined, both counts read 0 throughout.
